// File: rtl/cla_pkg.sv
// Shared constants, types and helpers for the pipelined carry-lookahead adder.
//   CLA_GROUP   default bits per lookahead group
//   CLA_GPS     default lookahead groups resolved per pipeline stage
//   cla_pg_t    group propagate/generate pair
//   cla_nstage  pipeline depth for a given width/group/gps split
package cla_pkg;

  localparam int unsigned CLA_GROUP = 4;
  localparam int unsigned CLA_GPS   = 2;

  typedef struct packed {
    logic p;  // every bit in the group propagates
    logic g;  // group generates a carry regardless of carry-in
  } cla_pg_t;

  function automatic int unsigned cla_nstage(input int unsigned width,
                                             input int unsigned group,
                                             input int unsigned gps);
    return width / (group * gps);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block.
//   a, b  : operand slices (b already inverted for subtract)
//   cin   : carry into bit 0 of the group
//   sum   : group sum bits
//   cout  : carry out of the top bit of the group
//   pg    : group propagate / generate, independent of cin
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output cla_pg_t          pg
);

  logic [GROUP-1:0] p_c;
  logic [GROUP-1:0] g_c;
  logic [GROUP:0]   c_c;
  logic             term_c;
  logic             grp_g_c;

  assign p_c = a ^ b;
  assign g_c = a & b;

  // Each carry is the flat sum-of-products back to the group base, so no
  // carry depends on a neighbouring carry inside the group.
  always_comb begin
    c_c     = '0;
    term_c  = 1'b0;
    grp_g_c = 1'b0;
    c_c[0]  = cin;
    for (int i = 0; i < int'(GROUP); i++) begin
      c_c[i+1] = cin;
      for (int k = 0; k <= i; k++) begin
        c_c[i+1] = c_c[i+1] & p_c[k];
      end
      for (int j = 0; j <= i; j++) begin
        term_c = g_c[j];
        for (int k = j + 1; k <= i; k++) begin
          term_c = term_c & p_c[k];
        end
        c_c[i+1] = c_c[i+1] | term_c;
      end
    end
    // Group generate: same expansion across the full group with cin = 0.
    for (int j = 0; j < int'(GROUP); j++) begin
      term_c = g_c[j];
      for (int k = j + 1; k < int'(GROUP); k++) begin
        term_c = term_c & p_c[k];
      end
      grp_g_c = grp_g_c | term_c;
    end
  end

  assign sum  = p_c ^ c_c[GROUP-1:0];
  assign cout = c_c[GROUP];
  assign pg.p = &p_c;
  assign pg.g = grp_g_c;

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// One beat per cycle, fixed latency NSTAGE = WIDTH/(GROUP*GPS).
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake (in_ready = !out_valid | out_ready)
//   in_a, in_b           operands
//   in_cin               carry-in for add; ignored when in_sub=1
//   in_sub               1 selects a - b
//   out_valid/out_ready  result handshake
//   out_sum              result modulo 2^WIDTH
//   out_cout             carry out of MSB (subtract: 1 = no borrow)
//   out_ovf              signed overflow
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = CLA_GROUP,
  parameter int unsigned GPS   = CLA_GPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NGRP   = WIDTH / GROUP;
  localparam int unsigned NSTAGE = cla_nstage(WIDTH, GROUP, GPS);
  localparam int unsigned LAST   = NSTAGE - 1;

  if ((WIDTH % (GROUP * GPS)) != 0 || NSTAGE == 0) begin : g_bad_cfg
    $error("cla_adder_pipe: WIDTH must be a nonzero multiple of GROUP*GPS");
  end

  // Stage bank k holds the state after stage k's groups are resolved.
  logic [NSTAGE-1:0] vld_q;
  logic [NSTAGE-1:0] c_q;
  logic [WIDTH-1:0]  a_q   [NSTAGE];
  logic [WIDTH-1:0]  b_q   [NSTAGE];
  logic [WIDTH-1:0]  sum_q [NSTAGE];
  logic              ovf_q;

  logic              adv_c;
  logic [WIDTH-1:0]  si_a_c   [NSTAGE];
  logic [WIDTH-1:0]  si_b_c   [NSTAGE];
  logic [WIDTH-1:0]  si_sum_c [NSTAGE];
  logic [NSTAGE-1:0] si_c_c;
  logic [WIDTH-1:0]  so_sum_c [NSTAGE];
  logic [NSTAGE-1:0] so_c_c;
  logic              ovf_c;
  logic              msb_cin_c;

  logic [GROUP-1:0]  gsum_c [NGRP];
  cla_pg_t           gpg_c  [NGRP];
  logic              unused_pg_c;

  // The whole pipe moves only when the output slot is free or being drained.
  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;

  // Stage inputs: stage 0 sees the (possibly inverted) operands, later stages the skew registers.
  always_comb begin
    si_a_c[0]   = in_a;
    si_b_c[0]   = in_sub ? ~in_b : in_b;
    si_sum_c[0] = '0;
    si_c_c      = '0;
    si_c_c[0]   = in_sub | in_cin;
    for (int k = 1; k < int'(NSTAGE); k++) begin
      si_a_c[k]   = a_q[k-1];
      si_b_c[k]   = b_q[k-1];
      si_sum_c[k] = sum_q[k-1];
      si_c_c[k]   = c_q[k-1];
    end
  end

  // Groups within a stage ripple their carries; stages are cut by registers.
  for (genvar k = 0; k < int'(NSTAGE); k++) begin : g_stg
    for (genvar j = 0; j < int'(GPS); j++) begin : g_grp
      localparam int unsigned GI = k * GPS + j;
      logic cin_c;
      logic cout_c;
      if (j == 0) begin : g_head
        assign cin_c = si_c_c[k];
      end else begin : g_link
        assign cin_c = g_grp[j-1].cout_c;
      end
      cla_group #(.GROUP(GROUP)) u_grp (
        .a    (si_a_c[k][GI*GROUP +: GROUP]),
        .b    (si_b_c[k][GI*GROUP +: GROUP]),
        .cin  (cin_c),
        .sum  (gsum_c[GI]),
        .cout (cout_c),
        .pg   (gpg_c[GI])
      );
    end
    assign so_c_c[k] = g_grp[GPS-1].cout_c;
  end

  // Merge this stage's freshly resolved sum bits into the running sum.
  always_comb begin
    for (int k = 0; k < int'(NSTAGE); k++) begin
      so_sum_c[k] = si_sum_c[k];
      for (int j = 0; j < int'(GPS); j++) begin
        so_sum_c[k][(k*int'(GPS)+j)*int'(GROUP) +: GROUP] = gsum_c[k*int'(GPS)+j];
      end
    end
    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
    msb_cin_c = si_a_c[LAST][WIDTH-1] ^ si_b_c[LAST][WIDTH-1] ^ so_sum_c[LAST][WIDTH-1];
    ovf_c     = so_c_c[LAST] ^ msb_cin_c;
  end

  // Group P/G are exposed for wider lookahead trees; here groups ripple within a stage.
  always_comb begin
    unused_pg_c = 1'b0;
    for (int g = 0; g < int'(NGRP); g++) begin
      unused_pg_c = unused_pg_c ^ gpg_c[g].p ^ gpg_c[g].g;
    end
  end

  // Stage and skew registers; everything holds while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(NSTAGE); k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv_c) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < int'(NSTAGE); k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < int'(NSTAGE); k++) begin
        a_q[k]   <= si_a_c[k];
        b_q[k]   <= si_b_c[k];
        sum_q[k] <= so_sum_c[k];
      end
      c_q   <= so_c_c;
      ovf_q <= ovf_c;
    end
  end

  assign out_valid = vld_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe (WIDTH=16, GROUP=4, GPS=2, latency 2).
module tb_cla_adder_pipe;

  typedef logic [17:0] res_t;  // {ovf, cout, sum}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int tests = 0;
  int fails = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(16), .GROUP(4), .GPS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    int ua, ub, sa, sb, full, sres;
    logic cout, ovf;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      full = ua - ub;
      cout = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + int'(cin);
      cout = (full > 65535);
      sres = sa + sb + int'(cin);
    end
    ovf = (sres > 32767) || (sres < -32768);
    return {ovf, cout, full[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: checks accept, 2-edge latency, result, and single-cycle presentation.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] esum,
                         input logic ecout, input logic eovf);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(out_sum), 32'(esum));
    check({tag, "_cout"}, 32'(out_cout), 32'(ecout));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(eovf));
    tick();
    check({tag, "_once"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic        prev_stall;
    logic [15:0] prev_sum;
    logic [15:0] ra, rb;
    logic        rc, rs;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_cout", 32'(out_cout), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic corners
    run_one("t1_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("t2_posovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("t2_negovf",  16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_one("t3_sub",     16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("t3_subovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("t_cin",      16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    run_one("t_stgcarry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Back-to-back beats with output stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
    in_a = 16'h0001; in_b = 16'h0002;
    tick();
    in_a = 16'h1000; in_b = 16'h2000;
    check("t4_rdy2", 32'(in_ready), 32'd1);
    tick();
    in_a = 16'h0010; in_b = 16'h0001; in_sub = 1'b1;
    check("t4_stall_rdy", 32'(in_ready), 32'd0);
    check("t4_first", 32'({out_valid, out_sum}), 32'({1'b1, 16'h0003}));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_rdy", 32'(in_ready), 32'd0);
      check("t4_hold_out", 32'({out_valid, out_sum}), 32'({1'b1, 16'h0003}));
    end
    out_ready = 1'b1;
    #1;
    check("t4_resume_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_sub = 1'b0;
    check("t4_second", 32'({out_valid, out_sum}), 32'({1'b1, 16'h3000}));
    tick();
    check("t4_third", 32'({out_valid, out_sum}), 32'({1'b1, 16'h000F}));
    tick();
    check("t4_drained", 32'(out_valid), 32'd0);

    // Reset with two beats in flight
    in_valid = 1'b1; in_a = 16'h0101; in_b = 16'h0202;
    tick();
    in_a = 16'h0303; in_b = 16'h0404;
    tick();
    in_valid = 1'b0;
    check("t5_inflight", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_clr", 32'(out_valid), 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_stale", 32'(out_valid), 32'd0);
    end
    run_one("t5_after", 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Randomized traffic against the reference model
    prev_stall = 1'b0;
    prev_sum = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (prev_stall)
        check("rnd_stall_hold", 32'({out_valid, out_sum}), 32'({1'b1, prev_sum}));
      ra = pick_operand();
      rb = pick_operand();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = ra; in_b = rb; in_cin = rc; in_sub = rs;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          check("rnd_spurious", 32'(out_valid), 32'd0);
        else
          check("rnd_result", 32'({out_ovf, out_cout, out_sum}), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(ra, rb, rc, rs));
      prev_stall = out_valid && !out_ready;
      prev_sum = out_sum;
      tick();
    end

    // Drain with a cycle budget
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      #1;
      if (out_valid)
        check("drain_result", 32'({out_ovf, out_cout, out_sum}), 32'(exp_q.pop_front()));
      tick();
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
